data_sync_hs: RTL and testbench

Parametrised handshake data synchroniser: the next generation of `data_sync`. It brings a multi-bit word from an asynchronous or foreign-timed source into the `clk` domain. Only the request line is synchronised, through a configurable flop chain. `din` is sampled once the request is seen and returned as an acknowledge. Captured words sit in a one-entry holding register with a valid/take handshake toward the consumer, and overrun is detected and counted. It sits at every slow-to-core data crossing in place of `data_sync`.

---
 rtl/data_sync_pkg.sv | 13 +
 rtl/sync_chain.sv | 29 ++
 rtl/data_sync_hs.sv | 120 ++++++++++++
 tb/tb_data_sync_hs.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
// Shared constants and state type for the handshake data synchronisers.
// MODE selects the request protocol; the holding register has two states.
package data_sync_pkg;

  localparam int MODE_LEVEL  = 0;
  localparam int MODE_TOGGLE = 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser; output lags input by STAGES edges.
// No flow control: every edge shifts, reset clears the chain to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s_q;
  logic [STAGES-1:0] s_d;

  always_comb begin
    s_d = {s_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign q = s_q[STAGES-1];

endmodule

// File: rtl/data_sync_hs.sv
// Handshake data crossing: synced request captures din, STAGES+1 edges after the request changes.
// One-entry holding register with valid/take; a capture while full and not taken overwrites and counts an overrun.
module data_sync_hs
  import data_sync_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int MODE   = MODE_LEVEL,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             dready_i,
  output logic             dack_o,
  output logic [WIDTH-1:0] dout,
  output logic             dready_o,
  input  logic             dtake_i,
  input  logic             clr_i,
  output logic             overrun_o,
  output logic [CNT_W-1:0] ovr_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             req_s;
  logic             req_d_q;
  logic             req_d_d;
  logic             cap_evt;
  logic             ovr_hit;
  hold_state_e      state_q;
  hold_state_e      state_d;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;
  logic             ovr_q;
  logic             ovr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  sync_chain #(
    .STAGES(STAGES)
  ) u_req_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (dready_i),
    .q   (req_s)
  );

  // Level mode captures only on the rising edge; toggle mode on either edge.
  always_comb begin
    if (MODE == MODE_TOGGLE) begin
      cap_evt = req_s ^ req_d_q;
    end else begin
      cap_evt = req_s & ~req_d_q;
    end
  end

  always_comb begin
    req_d_d = req_s;
    state_d = state_q;
    dout_d  = dout_q;
    ovr_hit = 1'b0;
    case (state_q)
      EMPTY: begin
        if (cap_evt) begin
          state_d = FULL;
          dout_d  = din;
        end
      end
      FULL: begin
        if (cap_evt) begin
          dout_d  = din;
          ovr_hit = ~dtake_i;
        end else if (dtake_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // An overrun landing in the same cycle as a clear survives as a fresh count of one.
  always_comb begin
    ovr_d = ovr_q;
    cnt_d = cnt_q;
    if (clr_i && ovr_hit) begin
      ovr_d = 1'b1;
      cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (clr_i) begin
      ovr_d = 1'b0;
      cnt_d = '0;
    end else if (ovr_hit) begin
      ovr_d = 1'b1;
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_d_q <= 1'b0;
      state_q <= EMPTY;
      dout_q  <= '0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      req_d_q <= req_d_d;
      state_q <= state_d;
      dout_q  <= dout_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dack_o    = req_d_q;
  assign dout      = dout_q;
  assign dready_o  = (state_q == FULL);
  assign overrun_o = ovr_q;
  assign ovr_cnt_o = cnt_q;

endmodule

// File: tb/tb_data_sync_hs.sv
// Directed bench for data_sync_hs: a level-mode and a toggle-mode instance on one clock.
module tb_data_sync_hs;

  logic       clk;
  logic       rstn;

  logic [7:0] din0, dout0;
  logic       drdy_i0, dack0, drdy_o0, dtake0, clr0, ovr0;
  logic [3:0] cnt0;

  logic [7:0] din1, dout1;
  logic       drdy_i1, dack1, drdy_o1, dtake1, clr1, ovr1;
  logic [3:0] cnt1;

  int tests_run;
  int tests_failed;

  data_sync_hs #(.WIDTH(8), .STAGES(2), .MODE(0), .CNT_W(4)) u_lvl (
    .clk(clk), .rstn(rstn), .din(din0), .dready_i(drdy_i0), .dack_o(dack0),
    .dout(dout0), .dready_o(drdy_o0), .dtake_i(dtake0), .clr_i(clr0),
    .overrun_o(ovr0), .ovr_cnt_o(cnt0)
  );

  data_sync_hs #(.WIDTH(8), .STAGES(2), .MODE(1), .CNT_W(4)) u_tgl (
    .clk(clk), .rstn(rstn), .din(din1), .dready_i(drdy_i1), .dack_o(dack1),
    .dout(dout1), .dready_o(drdy_o1), .dtake_i(dtake1), .clr_i(clr1),
    .overrun_o(ovr1), .ovr_cnt_o(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rstn    = 1'b0;
    din0 = 8'h00; drdy_i0 = 1'b0; dtake0 = 1'b0; clr0 = 1'b0;
    din1 = 8'h00; drdy_i1 = 1'b0; dtake1 = 1'b0; clr1 = 1'b0;
    tick(2);
    check("rst_dout", dout0, 0);
    check("rst_rdy", drdy_o0, 0);
    check("rst_ack", dack0, 0);
    check("rst_ovr", ovr0, 0);
    check("rst_cnt", cnt0, 0);
    rstn = 1'b1;
    tick(1);

    // din wiggles without a request
    din0 = 8'h55; tick(3);
    din0 = 8'hAA; tick(3);
    check("noreq_dout", dout0, 8'h00);
    check("noreq_rdy", drdy_o0, 0);

    // single four-phase transfer
    din0 = 8'hA5; drdy_i0 = 1'b1;
    tick(2);
    check("xfer_rdy_E2", drdy_o0, 0);
    check("xfer_ack_E2", dack0, 0);
    tick(1);
    check("xfer_dout_E3", dout0, 8'hA5);
    check("xfer_rdy_E3", drdy_o0, 1);
    check("xfer_ack_E3", dack0, 1);
    dtake0 = 1'b1; tick(1); dtake0 = 1'b0;
    check("xfer_take", drdy_o0, 0);
    drdy_i0 = 1'b0; tick(3);
    check("xfer_ack_fall", dack0, 0);
    check("xfer_fall_nocap", drdy_o0, 0);

    // overrun: two captures without a take
    din0 = 8'h11; drdy_i0 = 1'b1; tick(3);
    drdy_i0 = 1'b0; tick(3);
    check("ovr_first_flag", ovr0, 0);
    din0 = 8'h22; drdy_i0 = 1'b1; tick(3);
    check("ovr_dout", dout0, 8'h22);
    check("ovr_flag", ovr0, 1);
    check("ovr_cnt", cnt0, 1);
    drdy_i0 = 1'b0; tick(3);
    clr0 = 1'b1; tick(1); clr0 = 1'b0;
    check("clr_flag", ovr0, 0);
    check("clr_cnt", cnt0, 0);
    check("clr_keeps_rdy", drdy_o0, 1);
    dtake0 = 1'b1; tick(1); dtake0 = 1'b0;

    // take coinciding with a new capture
    din0 = 8'h33; drdy_i0 = 1'b1; tick(3);
    drdy_i0 = 1'b0; tick(3);
    check("sim_first", dout0, 8'h33);
    din0 = 8'h44; drdy_i0 = 1'b1; tick(2);
    dtake0 = 1'b1; tick(1); dtake0 = 1'b0;
    check("sim_dout", dout0, 8'h44);
    check("sim_rdy", drdy_o0, 1);
    check("sim_ovr", ovr0, 0);
    check("sim_cnt", cnt0, 0);

    // asynchronous reset mid-run, request still high at release
    rstn = 1'b0; #1;
    check("arst_dout", dout0, 0);
    check("arst_rdy", drdy_o0, 0);
    check("arst_ack", dack0, 0);
    din0 = 8'h5A;
    tick(1);
    rstn = 1'b1;
    tick(2);
    check("rel_rdy_E2", drdy_o0, 0);
    tick(1);
    check("rel_rdy_E3", drdy_o0, 1);
    check("rel_dout_E3", dout0, 8'h5A);
    drdy_i0 = 1'b0;

    // toggle mode: both edges capture
    din1 = 8'h01; drdy_i1 = 1'b1; tick(2);
    check("tgl1_rdy_E2", drdy_o1, 0);
    tick(1);
    check("tgl1_dout", dout1, 8'h01);
    check("tgl1_rdy", drdy_o1, 1);
    check("tgl1_ack", dack1, 1);
    dtake1 = 1'b1; tick(1); dtake1 = 1'b0;
    check("tgl1_take", drdy_o1, 0);
    din1 = 8'h02; drdy_i1 = 1'b0; tick(2);
    check("tgl2_rdy_E2", drdy_o1, 0);
    tick(1);
    check("tgl2_dout", dout1, 8'h02);
    check("tgl2_rdy", drdy_o1, 1);
    check("tgl2_ack", dack1, 0);
    dtake1 = 1'b1; tick(1); dtake1 = 1'b0;
    check("tgl2_ovr", ovr1, 0);

    // saturation: one fill then 20 overruns
    for (int i = 0; i < 21; i++) begin
      din1 = 8'(i); drdy_i1 = ~drdy_i1; tick(3);
      if (i == 1) check("sat_cnt1", cnt1, 1);
      if (i == 15) check("sat_cnt15", cnt1, 15);
    end
    check("sat_cnt", cnt1, 15);
    check("sat_ovr", ovr1, 1);
    check("sat_dout", dout1, 8'd20);

    // clear coinciding with an overrun: set wins
    drdy_i1 = ~drdy_i1; tick(2);
    clr1 = 1'b1; tick(1); clr1 = 1'b0;
    check("clrset_ovr", ovr1, 1);
    check("clrset_cnt", cnt1, 1);
    clr1 = 1'b1; tick(1); clr1 = 1'b0;
    check("clr1_cnt", cnt1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
